// File: rtl/pipe_pkg.sv
// Shared constants and the stage-command enum used by the pipeline registers.
package pipe_pkg;

  localparam int                EXC_W        = 5;
  localparam logic [EXC_W-1:0]  EXC_NONE     = 5'd0;
  localparam logic              CTRL_NOP     = '0;  // replicated to the control width; all-zero decodes as NOP
  localparam logic [31:0]       DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0]       DEF_FLUSH_PC = 32'h0000_4180;

  typedef enum logic [2:0] {
    CMD_RESET,
    CMD_FLUSH,
    CMD_HOLD,
    CMD_BUBBLE,
    CMD_LOAD
  } stage_cmd_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold, bubble, flush and Tnew ageing.
// Optional perf counters are enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 128,
  parameter int          CTRL_W   = 32,
  parameter int          TNEW_W   = 2,
  parameter int          DEC_TNEW = 1,
  parameter logic [31:0] FLUSH_PC = DEF_FLUSH_PC,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [31:0]       pc_i,
  input  logic              bd_i,
  input  logic [EXC_W-1:0]  exc_i,
  input  logic [TNEW_W-1:0] tnew_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [31:0]       pc_o,
  output logic              bd_o,
  output logic [EXC_W-1:0]  exc_o,
  output logic [TNEW_W-1:0] tnew_o,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       stall_cnt_o
);

  localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(1);

  stage_cmd_e        cmd;
  logic [TNEW_W-1:0] tnew_load;

  // One priority decode drives every field so they can never disagree.
  always_comb begin
    cmd = CMD_LOAD;
    if (reset) begin
      cmd = CMD_RESET;
    end else if (flush_i) begin
      cmd = CMD_FLUSH;
    end else if (stall_i) begin
      cmd = CMD_HOLD;
    end else if (bubble_i) begin
      cmd = CMD_BUBBLE;
    end
  end

  always_comb begin
    tnew_load = tnew_i;
    if ((DEC_TNEW != 0) && (tnew_i != '0)) begin
      tnew_load = tnew_i - TNEW_ONE;
    end
  end

  always_ff @(posedge clk) begin
    case (cmd)
      CMD_RESET: begin
        valid_o <= 1'b0;
        data_o  <= '0;
        ctrl_o  <= {CTRL_W{CTRL_NOP}};
        pc_o    <= RESET_PC;
        bd_o    <= 1'b0;
        exc_o   <= EXC_NONE;
        tnew_o  <= '0;
      end
      CMD_FLUSH: begin
        valid_o <= 1'b0;
        data_o  <= '0;
        ctrl_o  <= {CTRL_W{CTRL_NOP}};
        pc_o    <= FLUSH_PC;
        bd_o    <= 1'b0;
        exc_o   <= EXC_NONE;
        tnew_o  <= '0;
      end
      CMD_HOLD: begin
      end
      // PC and BD survive a bubble so a later exception still reports a precise EPC.
      CMD_BUBBLE: begin
        valid_o <= 1'b0;
        data_o  <= '0;
        ctrl_o  <= {CTRL_W{CTRL_NOP}};
        pc_o    <= pc_i;
        bd_o    <= bd_i;
        exc_o   <= EXC_NONE;
        tnew_o  <= '0;
      end
      default: begin
        valid_o <= valid_i;
        data_o  <= data_i;
        ctrl_o  <= ctrl_i;
        pc_o    <= pc_i;
        bd_o    <= bd_i;
        exc_o   <= exc_i;
        tnew_o  <= tnew_load;
      end
    endcase
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  pipe_sat_cnt #(.W(32)) u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (cmd == CMD_BUBBLE),
    .count (bubble_cnt_o)
  );

  pipe_sat_cnt #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (cmd == CMD_HOLD),
    .count (stall_cnt_o)
  );
`else
  assign bubble_cnt_o = 32'd0;
  assign stall_cnt_o  = 32'd0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core; one instance per boundary (F/D, D/E, E/M, M/W).
- Carries an opaque payload (operands, immediates, control word) plus architectural sideband: PC, branch-delay flag, exception code and Tnew.
- Adds stall (hold), bubble (NOP insertion keeping PC/BD for precise EPC), flush, valid tracking and automatic Tnew decrement.

Parameters:
- DATA_W, 128, width of opaque datapath payload (operands, EXT result, register indices).
- CTRL_W, 32, width of packed control word (RegWrite, MemOp, ALUOp, ...).
- TNEW_W, 2, width of Tnew field.
- DEC_TNEW, 1, 1 = Tnew decremented (saturating at 0) on every load; 0 = passed unchanged.
- FLUSH_PC, 32'h0000_4180, PC value written on flush.
- RESET_PC, 32'h0000_3000, PC value written on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  hold current contents
- bubble_i  in  1  load a NOP, keep pc_i/bd_i
- flush_i  in  1  clear stage, PC <= FLUSH_PC
- valid_i  in  1  upstream slot holds a real instruction
- data_i  in  DATA_W  payload
- ctrl_i  in  CTRL_W  control word
- pc_i  in  32  instruction PC
- bd_i  in  1  instruction is in a delay slot
- exc_i  in  5  exception code, 0 = none
- tnew_i  in  TNEW_W  cycles until result is ready
- valid_o, data_o, ctrl_o, pc_o, bd_o, exc_o, tnew_o  out  matching widths  registered copies
- bubble_cnt_o  out  32  bubbles inserted (optional feature)
- stall_cnt_o  out  32  stall cycles (optional feature)

Behaviour:
- All outputs are driven directly from flops; no combinational input-to-output path. Latency is 1 cycle.
- Each posedge clk evaluates in this strict priority order; the first matching case applies:
  1. reset: all fields 0, pc_o = RESET_PC, valid_o = 0, counters = 0.
  2. flush_i: data/ctrl/exc/tnew/bd = 0, valid_o = 0, pc_o = FLUSH_PC.
  3. stall_i: every field holds, including tnew_o (no decrement while held).
  4. bubble_i: data/ctrl/exc/tnew = 0, valid_o = 0; pc_o = pc_i, bd_o = bd_i.
  5. otherwise (load): all fields take their inputs; valid_o = valid_i.
     - tnew_o = DEC_TNEW ? (tnew_i == 0 ? 0 : tnew_i - 1) : tnew_i.
- ctrl_o = 0 must decode as NOP (RegWrite = 0, no memory op) throughout the core.
- exc_o is never cleared by stall. A load with valid_i = 0 still copies exc_i, so faults on a squashed fetch stay visible.
- Simultaneous events:
  - stall + bubble: hold (the stalled stage keeps its instruction).
  - flush + stall: flush.
  - reset mid-stall: reset.
- No internal state other than the registered fields (and counters when the optional feature is enabled).

Optional Feature:
- Macro PIPE_STAGE_REG_PERF_EN.
- Defined:
  - bubble_cnt_o increments on each cycle that case 4 applies.
  - stall_cnt_o increments on each cycle that case 3 applies.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and are cleared by reset only (flush does not clear them).
- Undefined: both ports tied to 32'd0 and no counter flops are synthesised; the port list is unchanged.

Decomposition:
- Package pipe_pkg holds:
  - EXC_W = 5 and EXC_NONE = 5'd0;
  - CTRL_NOP = '0;
  - RESET_PC / FLUSH_PC defaults;
  - the stage-command enum {CMD_RESET, CMD_FLUSH, CMD_HOLD, CMD_BUBBLE, CMD_LOAD}.
- Priority resolution is a single combinational decode to this enum, shared by all fields.
- One sub-module, pipe_sat_cnt (parametrised saturating counter with inc/clear), instantiated twice under PIPE_STAGE_REG_PERF_EN.

Test Plan:
- Reset: reset = 1 for 2 cycles -> valid_o = 0, pc_o = 32'h3000, ctrl_o = 0, tnew_o = 0; then load pc_i = 32'h3004, tnew_i = 2 -> next cycle pc_o = 32'h3004, tnew_o = 1 (DEC_TNEW = 1).
- Tnew boundary: load tnew_i = 0 -> tnew_o = 0 (no wrap); with DEC_TNEW = 0, tnew_i = 3 -> tnew_o = 3.
- Stall: stall_i = 1 for 3 cycles while inputs change -> all outputs frozen at prior values; stall_cnt_o += 3 (PERF build).
- Bubble: bubble_i = 1, pc_i = 32'h3010, bd_i = 1, ctrl_i = 32'hFFFF -> ctrl_o = 0, valid_o = 0, pc_o = 32'h3010, bd_o = 1; bubble_cnt_o += 1.
- Priority: flush_i = stall_i = bubble_i = 1 -> pc_o = 32'h4180, valid_o = 0; stall_i = bubble_i = 1 -> hold; reset asserted during a stall -> reset values.
- Exception passthrough: load valid_i = 0, exc_i = 5'd4 -> exc_o = 4, valid_o = 0; then bubble -> exc_o = 0.
